// File: rtl/imem_load_ctrl.sv
// Instruction-memory load sequencer: assembles big-endian byte pairs into 16-bit words
// and writes them while the CPU is stalled. Define IMEM_LOAD_CSUM_EN to add the load_csum output.
module imem_load_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              imem_we,
    output logic              cpu_stall,
    output logic              load_busy,
    output logic              load_done,
`ifdef IMEM_LOAD_CSUM_EN
    output logic              load_err,
    output logic [DATA_W-1:0] load_csum
`else
    output logic              load_err
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] word_q;
    logic              byte_ready_q, imem_we_q, stall_q, busy_q, done_q, err_q;
`ifdef IMEM_LOAD_CSUM_EN
    logic [DATA_W-1:0] csum_q;
`endif

    logic len_ok, last_word, hs;

    assign len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
    assign last_word = ({1'b0, cnt_q} == (len_q - LEN_ONE));
    assign hs        = byte_valid && byte_ready_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            stall_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        if (len_ok) begin
                            len_q        <= load_len;
                            cnt_q        <= '0;
                            state_q      <= S_HI;
                            byte_ready_q <= 1'b1;
                            stall_q      <= 1'b1;
                            busy_q       <= 1'b1;
`ifdef IMEM_LOAD_CSUM_EN
                            csum_q       <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_HI: begin
                    if (hs) begin
                        word_q[DATA_W-1 -: 8] <= byte_data;
                        state_q               <= S_LO;
                    end
                end
                S_LO: begin
                    // the write strobe is launched here so it is stable for the whole WRITE cycle
                    if (hs) begin
                        word_q[7:0]  <= byte_data;
                        state_q      <= S_WRITE;
                        byte_ready_q <= 1'b0;
                        imem_we_q    <= 1'b1;
                    end
                end
                S_WRITE: begin
`ifdef IMEM_LOAD_CSUM_EN
                    csum_q <= csum_q + word_q;
`endif
                    if (last_word) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q        <= cnt_q + CNT_ONE;
                        state_q      <= S_HI;
                        byte_ready_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                    stall_q      <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // only IDLE hands the memory port to the fetch stage
    assign imem_addr  = (state_q == S_IDLE) ? pc_addr : cnt_q;
    assign imem_wdata = word_q;
    assign imem_we    = imem_we_q;
    assign byte_ready = byte_ready_q;
    assign cpu_stall  = stall_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
`ifdef IMEM_LOAD_CSUM_EN
    assign load_csum  = csum_q;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed self-checking bench for imem_load_ctrl; load_csum checks follow IMEM_LOAD_CSUM_EN.
module tb_imem_load_ctrl;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc_addr = 9'h1A5;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, imem_we, cpu_stall, load_busy, load_done, load_err;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
`ifdef IMEM_LOAD_CSUM_EN
    logic [DW-1:0] load_csum;
`endif

    imem_load_ctrl dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
        .cpu_stall(cpu_stall), .load_busy(load_busy), .load_done(load_done),
`ifdef IMEM_LOAD_CSUM_EN
        .load_err(load_err), .load_csum(load_csum)
`else
        .load_err(load_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]    tx     [0:1023];
    logic [AW-1:0] w_addr [0:511];
    logic [DW-1:0] w_data [0:511];
    int n_w, done_cyc, done_cnt, stall_bad, ready_gap_bad;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts a load from IDLE and feeds tx[] bytes, recording writes and the done cycle.
    // Cycle 0 is the cycle load_start is presented; gap inserts idle byte_valid cycles
    // after every accepted byte; poke re-asserts load_start with len 3 in cycle 1.
    task automatic drive_load(input int len, input int gap, input bit poke);
        int idx = 0, gc = 0, cyc = 0, bound;
        bit hs;
        n_w = 0; done_cyc = -1; done_cnt = 0; stall_bad = 0; ready_gap_bad = 0;
        bound = 3*len + 1 + gap*2*len + 50;
        load_start = 1'b1; load_len = (AW+1)'(len);
        byte_valid = 1'b1; byte_data = tx[0];
        while (done_cyc < 0 && cyc < bound) begin
            hs = (byte_valid === 1'b1) && (byte_ready === 1'b1);
            step();
            cyc++;
            load_start = poke && (cyc == 1);
            if (poke && cyc == 1) load_len = 10'd3;
            if (hs) idx++;
            if (imem_we === 1'b1) begin
                if (n_w < 512) begin
                    w_addr[n_w] = imem_addr;
                    w_data[n_w] = imem_wdata;
                end
                n_w++;
            end
            if (cpu_stall !== 1'b1 || load_busy !== 1'b1) stall_bad++;
            if (byte_valid == 1'b0 && (idx % 2) == 1 && byte_ready !== 1'b1) ready_gap_bad++;
            if (load_done === 1'b1) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (hs) begin
                if (gap > 0) begin
                    byte_valid = 1'b0;
                    gc = gap;
                end else begin
                    byte_data = tx[idx];
                end
            end else if (byte_valid == 1'b0 && gc > 0) begin
                gc--;
                if (gc == 0) begin
                    byte_valid = 1'b1;
                    byte_data  = tx[idx];
                end
            end
        end
        byte_valid = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        n_cmp++;
        if ({byte_ready, imem_we, cpu_stall, load_busy, load_done, load_err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {byte_ready, imem_we, cpu_stall, load_busy, load_done, load_err});
        end
`ifdef IMEM_LOAD_CSUM_EN
        n_cmp++;
        if (load_csum !== 16'h0) begin n_bad++; $display("FAIL reset_csum: got %h want 0000", load_csum); end
`endif
        rst = 1'b1;
        step();
        n_cmp++;
        if (imem_addr !== 9'h1A5) begin n_bad++; $display("FAIL idle_pc_mux: got %h want 1a5", imem_addr); end
        pc_addr = 9'h033;
        #1;
        n_cmp++;
        if (imem_addr !== 9'h033) begin n_bad++; $display("FAIL idle_pc_comb: got %h want 033", imem_addr); end
        pc_addr = 9'h1A5;
        step();
    endtask

    task automatic test_basic();
        tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'hAB; tx[3] = 8'hCD;
        drive_load(2, 0, 1'b0);
        n_cmp++;
        if (n_w !== 2) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 2", n_w); end
        n_cmp++;
        if (w_addr[0] !== 9'd0 || w_data[0] !== 16'h1234) begin
            n_bad++; $display("FAIL basic_w0: got %h/%h want 000/1234", w_addr[0], w_data[0]);
        end
        n_cmp++;
        if (w_addr[1] !== 9'd1 || w_data[1] !== 16'hABCD) begin
            n_bad++; $display("FAIL basic_w1: got %h/%h want 001/abcd", w_addr[1], w_data[1]);
        end
        n_cmp++;
        if (done_cyc !== 7) begin n_bad++; $display("FAIL basic_done_cyc: got %0d want 7", done_cyc); end
        n_cmp++;
        if (stall_bad !== 0) begin n_bad++; $display("FAIL basic_stall: got %0d drops want 0", stall_bad); end
`ifdef IMEM_LOAD_CSUM_EN
        n_cmp++;
        if (load_csum !== 16'hBE01) begin n_bad++; $display("FAIL basic_csum: got %h want be01", load_csum); end
`endif
        step();
        n_cmp++;
        if ({cpu_stall, load_busy, load_done} !== 3'b0 || imem_addr !== 9'h1A5) begin
            n_bad++;
            $display("FAIL basic_resume: got stall/busy/done %b addr %h want 000 1a5",
                     {cpu_stall, load_busy, load_done}, imem_addr);
        end
`ifdef IMEM_LOAD_CSUM_EN
        step();
        n_cmp++;
        if (load_csum !== 16'hBE01) begin n_bad++; $display("FAIL basic_csum_hold: got %h want be01", load_csum); end
`endif
    endtask

    task automatic test_len_err();
        logic [AW:0] bad_len [0:1];
        bad_len[0] = 10'd0;
        bad_len[1] = 10'd513;
        for (int i = 0; i < 2; i++) begin
            load_start = 1'b1; load_len = bad_len[i]; byte_valid = 1'b1;
            step();
            load_start = 1'b0;
            n_cmp++;
            if (load_err !== 1'b1 || {cpu_stall, load_busy, byte_ready, imem_we} !== 4'b0) begin
                n_bad++;
                $display("FAIL len_err_%0d: got err %b flags %b want 1 0000", bad_len[i], load_err,
                         {cpu_stall, load_busy, byte_ready, imem_we});
            end
            step();
            n_cmp++;
            if (load_err !== 1'b0 || {cpu_stall, byte_ready, imem_we} !== 3'b0 || imem_addr !== pc_addr) begin
                n_bad++;
                $display("FAIL len_err_idle_%0d: got err %b flags %b addr %h want 0 000 1a5", bad_len[i],
                         load_err, {cpu_stall, byte_ready, imem_we}, imem_addr);
            end
            byte_valid = 1'b0;
        end
    endtask

    task automatic test_gaps();
        tx[0] = 8'h5A; tx[1] = 8'hC3;
        drive_load(1, 5, 1'b0);
        n_cmp++;
        if (n_w !== 1 || w_addr[0] !== 9'd0 || w_data[0] !== 16'h5AC3) begin
            n_bad++; $display("FAIL gap_write: got n=%0d %h/%h want 1 000/5ac3", n_w, w_addr[0], w_data[0]);
        end
        n_cmp++;
        if (done_cyc !== 9) begin n_bad++; $display("FAIL gap_done_cyc: got %0d want 9", done_cyc); end
        n_cmp++;
        if (ready_gap_bad !== 0) begin n_bad++; $display("FAIL gap_ready: got %0d drops want 0", ready_gap_bad); end
        step();
        n_cmp++;
        if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL gap_resume: got stall %b want 0", cpu_stall); end
    endtask

    task automatic test_ignore_busy();
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44; tx[4] = 8'h55; tx[5] = 8'h66;
        drive_load(1, 0, 1'b1);
        n_cmp++;
        if (n_w !== 1 || w_data[0] !== 16'h1122) begin
            n_bad++; $display("FAIL busy_ignore_write: got n=%0d data %h want 1 1122", n_w, w_data[0]);
        end
        n_cmp++;
        if (done_cyc !== 4) begin n_bad++; $display("FAIL busy_ignore_done: got %0d want 4", done_cyc); end
        step();
        n_cmp++;
        if ({cpu_stall, load_busy, byte_ready} !== 3'b0) begin
            n_bad++; $display("FAIL busy_ignore_idle: got %b want 000", {cpu_stall, load_busy, byte_ready});
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        load_start = 1'b1; load_len = 10'd2; byte_valid = 1'b1; byte_data = 8'h77;
        step();
        load_start = 1'b0;
        step();
        byte_data = 8'h88;
        n_cmp++;
        if (byte_ready !== 1'b1 || cpu_stall !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_lo: got ready/stall %b want 11", {byte_ready, cpu_stall});
        end
        rst = 1'b0; byte_valid = 1'b0;
        step();
        n_cmp++;
        if ({cpu_stall, load_busy, byte_ready, imem_we, load_done} !== 5'b0 || imem_addr !== pc_addr) begin
            n_bad++;
            $display("FAIL rst_mid_abort: got %b addr %h want 00000 1a5",
                     {cpu_stall, load_busy, byte_ready, imem_we, load_done}, imem_addr);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (load_done === 1'b1 || imem_we === 1'b1 || cpu_stall === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_full();
        int seq_bad = 0;
        logic [DW-1:0] sum = '0;
        for (int k = 0; k < 1024; k++) tx[k] = 8'(k) ^ 8'h5A;
        drive_load(512, 0, 1'b0);
        n_cmp++;
        if (n_w !== 512) begin n_bad++; $display("FAIL full_nwrites: got %0d want 512", n_w); end
        for (int i = 0; i < 512 && i < n_w; i++) begin
            sum = sum + {tx[2*i], tx[2*i+1]};
            if (w_addr[i] !== 9'(i) || w_data[i] !== {tx[2*i], tx[2*i+1]}) seq_bad++;
        end
        n_cmp++;
        if (seq_bad !== 0) begin n_bad++; $display("FAIL full_sequence: got %0d bad words want 0", seq_bad); end
        n_cmp++;
        if (w_addr[511] !== 9'h1FF || w_data[511] !== {tx[1022], tx[1023]}) begin
            n_bad++; $display("FAIL full_last: got %h/%h want 1ff/%h", w_addr[511], w_data[511],
                              {tx[1022], tx[1023]});
        end
        n_cmp++;
        if (done_cyc !== 1537) begin n_bad++; $display("FAIL full_done_cyc: got %0d want 1537", done_cyc); end
        n_cmp++;
        if (stall_bad !== 0) begin n_bad++; $display("FAIL full_stall: got %0d drops want 0", stall_bad); end
`ifdef IMEM_LOAD_CSUM_EN
        n_cmp++;
        if (load_csum !== sum) begin n_bad++; $display("FAIL full_csum: got %h want %h", load_csum, sum); end
`endif
        step();
        n_cmp++;
        if (cpu_stall !== 1'b0 || imem_addr !== pc_addr) begin
            n_bad++; $display("FAIL full_resume: got stall %b addr %h want 0 1a5", cpu_stall, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_err();
        test_gaps();
        test_ignore_busy();
        test_reset_mid();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
